alu_cmd_issue: RTL and testbench



---
 rtl/alu_cmd_issue.sv | 69 ++++++
 tb/tb_alu_cmd_issue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command FIFO and issue stage that tags results of a 2-edge-latency registered ALU
module alu_cmd_issue #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int TAGW  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  input  logic [1:0]               in_op,
  input  logic                     issue_en,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic [1:0]               alu_op,
  input  logic [2*N-1:0]           alu_res,
  output logic                     res_valid,
  output logic [2*N-1:0]           res_data,
  output logic [TAGW-1:0]          res_tag,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + 2 * N;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_count;
  logic            r_v1, r_v2;
  logic [TAGW-1:0] r_t1, r_t2, r_tag;
  logic            w_push, w_issue;
  logic [EW-1:0]   w_head;
  // in_ready looks only at registered occupancy, so a full FIFO refuses even while popping
  always_comb begin
    in_ready  = r_count < (AW+1)'(DEPTH);
    w_push    = in_valid && in_ready;
    w_issue   = issue_en && (r_count != '0);
    w_head    = r_mem[r_rp];
    {alu_op, alu_a, alu_b} = w_issue ? w_head : '0;
    count     = r_count;
    res_valid = r_v2;
    res_tag   = r_t2;
    res_data  = alu_res;
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {in_op, in_a, in_b};
  // v1/v2 mirror the ALU's input and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_t1    <= '0;
      r_t2    <= '0;
      r_tag   <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_issue) r_rp <= r_rp + 1'b1;
      if (w_issue) r_tag <= r_tag + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_issue);
      r_v1    <= w_issue;
      r_t1    <= r_tag;
      r_v2    <= r_v1;
      r_t2    <= r_t1;
    end
  end
endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: directed test of alu_cmd_issue against a behavioural 2-register ALU
module tb_alu_cmd_issue;
  logic       clk = 0, rst = 0, in_valid = 0, in_ready, issue_en = 0, res_valid;
  logic [3:0] in_a = 0, in_b = 0, alu_a, alu_b;
  logic [1:0] in_op = 0, alu_op, res_tag;
  logic [7:0] alu_res, res_data;
  logic [2:0] count;
  int vecs = 0, errs = 0;
  logic [3:0] fa [4], fb [4], wa [6], wb [6], ga [4], gb [4];
  logic [1:0] fo [4], wo [6], go [4];
  logic [7:0] fe [4], we [6], ge [4];
  logic [3:0] ma, mb;
  logic [1:0] mop;

  alu_cmd_issue #(.N(4), .DEPTH(4), .TAGW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .issue_en(issue_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0: return {4'd0, a} + {4'd0, b};
      2'd1: return {4'd0, a} * {4'd0, b};
      2'd2: return {4'd0, a} - {4'd0, b};
      default: return {4'd0, a & b};
    endcase
  endfunction

  // ALU model: input register then output register, reset by ~rst
  always @(posedge clk)
    if (!rst) begin
      ma <= 0; mb <= 0; mop <= 0; alu_res <= 0;
    end else begin
      ma <= alu_a; mb <= alu_b; mop <= alu_op; alu_res <= alu_f(ma, mb, mop);
    end

  task automatic nx;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 0; in_valid = 0; issue_en = 0;
    nx;
    rst = 1;
  endtask

  task automatic fill;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_a = fa[i]; in_b = fb[i]; in_op = fo[i]; issue_en = 0;
      nx;
    end
    in_valid = 0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    vecs++; if ({alu_op, alu_a, alu_b} !== 10'd0) begin errs++; $display("FAIL reset_alu_in got %h want 0", {alu_op, alu_a, alu_b}); end
  endtask

  task automatic test_basic;
    do_reset;
    in_valid = 1; in_a = 3; in_b = 5; in_op = 0; issue_en = 1;
    #1;
    vecs++; if (alu_a !== 4'd0) begin errs++; $display("FAIL basic_no_bypass got %0d want 0", alu_a); end
    nx; in_valid = 0; #1;
    vecs++; if ({alu_op, alu_a, alu_b} !== {2'd0, 4'd3, 4'd5}) begin errs++; $display("FAIL basic_issue got %h want %h", {alu_op, alu_a, alu_b}, {2'd0, 4'd3, 4'd5}); end
    nx; #1;
    vecs++; if (res_valid !== 1'b0 || count !== 3'd0) begin errs++; $display("FAIL basic_k1 got v=%b c=%0d want v=0 c=0", res_valid, count); end
    nx; #1;
    vecs++; if (res_valid !== 1'b1 || res_data !== 8'h08 || res_tag !== 2'd0) begin errs++; $display("FAIL basic_result got v=%b d=%h t=%0d want v=1 d=08 t=0", res_valid, res_data, res_tag); end
    nx; #1;
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL basic_one_shot got %b want 0", res_valid); end
  endtask

  task automatic test_fill;
    logic ev;
    do_reset;
    fill;
    #1;
    vecs++; if (count !== 3'd4 || in_ready !== 1'b0) begin errs++; $display("FAIL fill_full got c=%0d r=%b want c=4 r=0", count, in_ready); end
    in_valid = 1; in_a = 1; in_b = 1; in_op = 0;
    nx; in_valid = 0; #1;
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_refuse got %0d want 4", count); end
    issue_en = 1;
    for (int j = 0; j < 7; j++) begin
      #1;
      ev = (j >= 2 && j <= 5);
      vecs++; if (res_valid !== ev) begin errs++; $display("FAIL drain_valid j=%0d got %b want %b", j, res_valid, ev); end
      if (ev) begin
        vecs++; if (res_data !== fe[j-2] || res_tag !== 2'(j-2)) begin errs++; $display("FAIL drain_data j=%0d got d=%h t=%0d want d=%h t=%0d", j, res_data, res_tag, fe[j-2], 2'(j-2)); end
      end
      nx;
    end
    issue_en = 0; #1;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL drain_count got %0d want 0", count); end
  endtask

  task automatic test_full_pop;
    do_reset;
    fill;
    in_valid = 1; in_a = 1; in_b = 2; in_op = 0; issue_en = 1;
    #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fullpop_ready got %b want 0", in_ready); end
    nx; issue_en = 0; #1;
    vecs++; if (count !== 3'd3 || in_ready !== 1'b1) begin errs++; $display("FAIL fullpop_after got c=%0d r=%b want c=3 r=1", count, in_ready); end
    nx; in_valid = 0; #1;
    vecs++; if (count !== 3'd4 || in_ready !== 1'b0) begin errs++; $display("FAIL fullpop_refill got c=%0d r=%b want c=4 r=0", count, in_ready); end
  endtask

  task automatic test_wrap;
    logic ev;
    do_reset;
    for (int j = 0; j < 10; j++) begin
      in_valid = (j < 6); issue_en = 1;
      if (j < 6) begin in_a = wa[j]; in_b = wb[j]; in_op = wo[j]; end
      #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL wrap_ready j=%0d got %b want 1", j, in_ready); end
      if (j >= 1 && j <= 6) begin
        vecs++; if ({alu_op, alu_a, alu_b} !== {wo[j-1], wa[j-1], wb[j-1]}) begin errs++; $display("FAIL wrap_issue j=%0d got %h want %h", j, {alu_op, alu_a, alu_b}, {wo[j-1], wa[j-1], wb[j-1]}); end
      end
      ev = (j >= 3 && j <= 8);
      vecs++; if (res_valid !== ev) begin errs++; $display("FAIL wrap_valid j=%0d got %b want %b", j, res_valid, ev); end
      if (ev) begin
        vecs++; if (res_data !== we[j-3] || res_tag !== 2'(j-3)) begin errs++; $display("FAIL wrap_data j=%0d got d=%h t=%0d want d=%h t=%0d", j, res_data, res_tag, we[j-3], 2'(j-3)); end
      end
      nx;
    end
    issue_en = 0; #1;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL wrap_count got %0d want 0", count); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    fill;
    issue_en = 1;
    nx;
    in_valid = 1; in_a = 4; in_b = 4; in_op = 0;
    nx;
    in_valid = 0; issue_en = 0; #1;
    vecs++; if (res_valid !== 1'b1 || count !== 3'd3) begin errs++; $display("FAIL mid_pre got v=%b c=%0d want v=1 c=3", res_valid, count); end
    rst = 0;
    nx; rst = 1; #1;
    vecs++; if (res_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin errs++; $display("FAIL mid_post got v=%b c=%0d r=%b want v=0 c=0 r=1", res_valid, count, in_ready); end
    in_valid = 1; in_a = 5; in_b = 5; in_op = 0; issue_en = 1;
    nx; in_valid = 0; #1;
    vecs++; if (res_valid !== 1'b0 || alu_a !== 4'd5) begin errs++; $display("FAIL mid_issue got v=%b a=%0d want v=0 a=5", res_valid, alu_a); end
    nx; #1;
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL mid_flush got %b want 0", res_valid); end
    nx; #1;
    vecs++; if (res_valid !== 1'b1 || res_data !== 8'd10 || res_tag !== 2'd0) begin errs++; $display("FAIL mid_result got v=%b d=%h t=%0d want v=1 d=0a t=0", res_valid, res_data, res_tag); end
    issue_en = 0;
  endtask

  task automatic test_gap;
    int k;
    logic ev;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_a = ga[i]; in_b = gb[i]; in_op = go[i]; issue_en = 0;
      nx;
    end
    in_valid = 0;
    k = 0;
    for (int j = 0; j < 10; j++) begin
      issue_en = (j < 2 || j == 5 || j == 6);
      #1;
      if (j == 4) begin
        vecs++; if (count !== 3'd2) begin errs++; $display("FAIL gap_hold got %0d want 2", count); end
      end
      ev = (j == 2 || j == 3 || j == 7 || j == 8);
      vecs++; if (res_valid !== ev) begin errs++; $display("FAIL gap_valid j=%0d got %b want %b", j, res_valid, ev); end
      if (ev) begin
        vecs++; if (res_data !== ge[k] || res_tag !== 2'(k)) begin errs++; $display("FAIL gap_data j=%0d got d=%h t=%0d want d=%h t=%0d", j, res_data, res_tag, ge[k], 2'(k)); end
        k++;
      end
      nx;
    end
    issue_en = 0;
  endtask

  initial begin
    fa = '{4'd15, 4'd2, 4'd12, 4'd9};  fb = '{4'd15, 4'd5, 4'd10, 4'd6};
    fo = '{2'd1, 2'd2, 2'd3, 2'd0};    fe = '{8'd225, 8'hFD, 8'h08, 8'd15};
    wa = '{4'd1, 4'd2, 4'd7, 4'd15, 4'd8, 4'd15};
    wb = '{4'd1, 4'd3, 4'd4, 4'd3, 4'd8, 4'd1};
    wo = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    we = '{8'd2, 8'd6, 8'd3, 8'd3, 8'd16, 8'd14};
    ga = '{4'd3, 4'd10, 4'd6, 4'd7};   gb = '{4'd3, 4'd2, 4'd5, 4'd7};
    go = '{2'd1, 2'd2, 2'd3, 2'd0};    ge = '{8'd9, 8'd8, 8'd4, 8'd14};
    test_reset;
    test_basic;
    test_fill;
    test_full_pop;
    test_wrap;
    test_reset_mid;
    test_gap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
